hs_spi_reg_bridge_m: RTL

//  Register-access front end for the high-speed SPI master. Converts single register

---
 rtl/hs_spi_reg_bridge_m.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/hs_spi_reg_bridge_m.sv
`default_nettype none
// ============================================================================
// Module  : hs_spi_reg_bridge_m
// Brief   : Turns one register read/write request into a command word plus a
//           data word on the SPI master's load/empty/busy interface.
// Revision: 1.0 - initial release
// ============================================================================
module hs_spi_reg_bridge_m #(
    parameter int DW      = 32,
    parameter int AW      = 16,
    parameter int GAP_CYC = 4,
    parameter int TO_CYC  = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic          i_req_we,
    input  logic [AW-1:0] i_req_addr,
    input  logic [DW-1:0] i_req_wdata,
    output logic          o_rsp_valid,
    output logic [DW-1:0] o_rsp_rdata,
    output logic          o_rsp_err,
    output logic          o_spi_load,
    input  logic          i_spi_empty,
    input  logic          i_spi_busy,
    output logic [DW-1:0] o_spi_wdata,
    input  logic [DW-1:0] i_spi_rdata
);

    localparam int CNT_MAX = (TO_CYC > GAP_CYC) ? TO_CYC : GAP_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD_LD = 3'd1,
        S_CMD_WT = 3'd2,
        S_GAP    = 3'd3,
        S_DAT_LD = 3'd4,
        S_DAT_WT = 3'd5,
        S_RSP    = 3'd6
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_seen_busy;
    logic          r_req_ready;
    logic          r_we;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_spi_wdata;
    logic [DW-1:0] r_rsp_rdata;
    logic          r_rsp_err;
    logic [DW-1:0] w_cmd;
    logic          w_accept;
    logic          w_load;
    logic          w_done;
    logic          w_timeout;
    logic          w_to_limit;
    logic          w_gap_end;
    logic          w_cnt_clr;

    always_comb begin
        w_cmd                 = '0;
        w_cmd[DW-1]           = i_req_we;
        w_cmd[DW-2 -: AW]     = i_req_addr;
    end

    assign w_accept   = (r_state == S_IDLE) && r_req_ready && i_req_valid;
    assign w_to_limit = (r_cnt >= CW'(TO_CYC - 1));
    assign w_gap_end  = (r_cnt >= CW'(GAP_CYC - 1));
    assign w_cnt_clr  = (w_state_nxt != r_state) &&
                        (w_state_nxt inside {S_CMD_LD, S_GAP, S_DAT_LD});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_done      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_CMD_LD;
                end
            end
            S_CMD_LD, S_DAT_LD: begin
                // A load wins over an expiring timer: the word is then in the master's hands.
                if (i_spi_empty) begin
                    w_load      = 1'b1;
                    w_state_nxt = (r_state == S_CMD_LD) ? S_CMD_WT : S_DAT_WT;
                end else if (w_to_limit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_RSP;
                end
            end
            S_CMD_WT, S_DAT_WT: begin
                if (r_seen_busy && !i_spi_busy) begin
                    w_done      = 1'b1;
                    w_state_nxt = (r_state == S_CMD_WT) ? S_GAP : S_RSP;
                end else if (w_to_limit) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_RSP;
                end
            end
            S_GAP: begin
                if (w_gap_end) begin
                    w_state_nxt = S_DAT_LD;
                end
            end
            S_RSP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_seen_busy <= 1'b0;
            r_req_ready <= 1'b0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_spi_wdata <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_req_ready <= (w_state_nxt == S_IDLE);

            // One counter serves both the per-word timeout and the inter-word gap.
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (r_state != S_IDLE) begin
                r_cnt <= r_cnt + CW'(1);
            end

            if (w_load) begin
                r_seen_busy <= 1'b0;
            end else if ((r_state == S_CMD_WT || r_state == S_DAT_WT) && i_spi_busy) begin
                r_seen_busy <= 1'b1;
            end

            if (w_accept) begin
                r_we        <= i_req_we;
                r_wdata     <= i_req_wdata;
                r_spi_wdata <= w_cmd;
            end else if (r_state == S_GAP && w_state_nxt == S_DAT_LD) begin
                r_spi_wdata <= r_we ? r_wdata : '0;
            end

            if (w_timeout) begin
                r_rsp_rdata <= '0;
                r_rsp_err   <= 1'b1;
            end else if (w_done && r_state == S_DAT_WT) begin
                r_rsp_rdata <= r_we ? '0 : i_spi_rdata;
                r_rsp_err   <= 1'b0;
            end
        end
    end

    assign o_req_ready = r_req_ready;
    assign o_rsp_valid = (r_state == S_RSP);
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;
    assign o_spi_load  = w_load;
    assign o_spi_wdata = r_spi_wdata;

endmodule
`default_nettype wire
